// File: rtl/pipeline_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_load_ctrl_pkg : shared processor defines (FSM encoding, widths)
// Revision: 1.0
// ============================================================================
package pipeline_load_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// load_use_detect : flags an ID source that depends on a load currently in EX
// Revision: 1.0
// ============================================================================
module load_use_detect
    import pipeline_load_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_load_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_load_ctrl : pipeline register load/flush sequencing for a 5-stage
// core on a two-phase unified memory. Optional macro STALL_COUNTER_EN.
// Revision: 1.0
// ============================================================================
module pipeline_load_ctrl
    import pipeline_load_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch_taken,
    input  logic             wb_halt,
    output logic             mem_phase,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [31:0]      stall_count
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_mem_phase;
    logic   w_adv;
    logic   w_load_use;
    logic   w_bubble;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (w_load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_mem_phase <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_phase <= (r_state == RUN) ? ~r_mem_phase : 1'b0;
        end
    end

    assign w_adv     = !reset && (r_state == RUN) && r_mem_phase;
    assign mem_phase = r_mem_phase;
    assign halted    = (r_state == HALT);

    // Priority: halt request, then taken branch, then load-use bubble
    always_comb begin
        w_state_nxt  = r_state;
        w_bubble     = 1'b0;
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (w_adv) begin
            if (wb_halt) begin
                w_state_nxt = HALT;
            end else if (mem_branch_taken) begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (w_load_use) begin
                w_bubble    = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_load     = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 32'd0;
        end else if (w_bubble) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    logic w_bubble_unused;
    assign w_bubble_unused = w_bubble;
    assign stall_count     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_load_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_load_ctrl : directed vectors with a queue-based scoreboard
// Revision: 1.0
// ============================================================================
module tb_pipeline_load_ctrl;

`ifdef STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // {phase, pc, if_id, id_ex, ex_mem, mem_wb loads, if_id/id_ex/ex_mem flush, halted}
    localparam logic [9:0] P0_IDLE = 10'b0_00000_000_0;
    localparam logic [9:0] P1_RUN  = 10'b1_11111_000_0;
    localparam logic [9:0] P1_BUB  = 10'b1_00111_010_0;
    localparam logic [9:0] P1_BR   = 10'b1_11111_111_0;
    localparam logic [9:0] P1_HREQ = 10'b1_00000_000_0;
    localparam logic [9:0] HALTED  = 10'b0_00000_000_1;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_mem_read, mem_branch_taken, wb_halt;
    logic        mem_phase, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [31:0] stall_count;

    typedef struct {
        string       name;
        logic [9:0]  ctrl;
        logic [31:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;

    pipeline_load_ctrl #(.REG_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rs1_used      (id_rs1_used),
        .id_rs2_used      (id_rs2_used),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .mem_branch_taken (mem_branch_taken),
        .wb_halt          (wb_halt),
        .mem_phase        (mem_phase),
        .pc_load          (pc_load),
        .if_id_load       (if_id_load),
        .id_ex_load       (id_ex_load),
        .ex_mem_load      (ex_mem_load),
        .mem_wb_load      (mem_wb_load),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .halted           (halted),
        .stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge and queue its expectation
    task automatic step(input string name, input logic rst_v,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic wh,
                        input logic [9:0] exp_ctrl);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst_v;
        id_rs1           = rs1;
        id_rs2           = rs2;
        id_rs1_used      = u1;
        id_rs2_used      = u2;
        ex_rd            = rd;
        ex_mem_read      = mr;
        mem_branch_taken = br;
        wb_halt          = wh;
        e.name  = name;
        e.ctrl  = exp_ctrl;
        e.stall = exp_stall;
        sb.push_back(e);
    endtask

    task automatic idle(input string name, input logic rst_v, input logic [9:0] exp_ctrl);
        step(name, rst_v, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ctrl);
    endtask

    // Hazard pattern: load into x5 while the ID instruction reads x5 through rs2
    task automatic haz(input string name, input logic rst_v, input logic br,
                       input logic wh, input logic [9:0] exp_ctrl);
        step(name, rst_v, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, br, wh, exp_ctrl);
    endtask

    // Monitor: compare the queued expectation against the DUT on each falling edge
    initial begin
        exp_t        e;
        logic [9:0]  act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {mem_phase, pc_load, if_id_load, id_ex_load, ex_mem_load,
                       mem_wb_load, if_id_flush, id_ex_flush, ex_mem_flush, halted};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b required %b", e.name, act, e.ctrl);
                end
                checks++;
                if (stall_count !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall_count: got %h required %h", e.name, stall_count, e.stall);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        mem_branch_taken = 1'b0; wb_halt = 1'b0;

        idle("rst0", 1'b1, P0_IDLE);
        idle("rst1", 1'b1, P0_IDLE);

        // Free-running advance pattern; a halt seen in phase 0 has no effect
        idle("run_c0", 1'b0, P0_IDLE);
        idle("run_c1", 1'b0, P1_RUN);
        step("halt_ph0", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, P0_IDLE);
        idle("run_c3", 1'b0, P1_RUN);

        // Load-use on rs2
        haz("bub_rs2_ph0", 1'b0, 1'b0, 1'b0, P0_IDLE);
        haz("bub_rs2_adv", 1'b0, 1'b0, 1'b0, P1_BUB);
        if (CNT_EN) exp_stall = exp_stall + 32'd1;

        // Load into x0 never stalls
        step("rd0_ph0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, P0_IDLE);
        step("rd0_adv", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, P1_RUN);

        // Load-use on rs1
        step("bub_rs1_ph0", 1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P0_IDLE);
        step("bub_rs1_adv", 1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P1_BUB);
        if (CNT_EN) exp_stall = exp_stall + 32'd1;

        // Matching index but source not read, then matching index with no load
        step("unused_ph0", 1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P0_IDLE);
        step("unused_adv", 1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P1_RUN);
        step("noload_ph0", 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, P0_IDLE);
        step("noload_adv", 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, P1_RUN);

        // Taken branch overrides the bubble
        haz("br_ph0", 1'b0, 1'b1, 1'b0, P0_IDLE);
        haz("br_adv", 1'b0, 1'b1, 1'b0, P1_BR);
        idle("pre_halt", 1'b0, P0_IDLE);

        // Halt beats branch and bubble, then holds until reset
        haz("halt_adv", 1'b0, 1'b1, 1'b1, P1_HREQ);
        for (int i = 0; i < 10; i++) haz("halted_hold", 1'b0, 1'b1, 1'b0, HALTED);
        exp_stall = 32'd0;
        idle("halt_rst", 1'b1, P0_IDLE);
        idle("rel_c0", 1'b0, P0_IDLE);
        idle("rel_c1", 1'b0, P1_RUN);

        // Reset mid-bubble sequence clears the counter at once
        haz("mb_ph0", 1'b0, 1'b0, 1'b0, P0_IDLE);
        haz("mb_adv", 1'b0, 1'b0, 1'b0, P1_BUB);
        if (CNT_EN) exp_stall = exp_stall + 32'd1;
        haz("mb_after", 1'b0, 1'b0, 1'b0, P0_IDLE);
        exp_stall = 32'd0;
        haz("mb_rst", 1'b1, 1'b0, 1'b0, P0_IDLE);

        // Counter wrap from all-ones
        if (CNT_EN) exp_stall = 32'hFFFF_FFFF;
        idle("wrap_c0", 1'b0, P0_IDLE);
`ifdef STALL_COUNTER_EN
        force dut.r_stall_count = 32'hFFFF_FFFF;
        @(negedge clk);
        #2;
        release dut.r_stall_count;
`endif
        haz("wrap_adv", 1'b0, 1'b0, 1'b0, P1_BUB);
        if (CNT_EN) exp_stall = exp_stall + 32'd1;
        idle("wrap_after", 1'b0, P0_IDLE);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
